// File: rtl/nn_pkg.sv
// nn_pkg: shared constants and types for NN address generation and b accumulation
package nn_pkg;
    localparam int DEPTH_DEF  = 100;
    localparam int K_DEF      = 502;
    localparam int NN_OUT_DEF = 10;
    localparam int Q_DEF      = 16;
    localparam int LAT_DEF    = 2;
    localparam int HALF_K     = K_DEF / 2;
    localparam int B_WORDS    = NN_OUT_DEF * HALF_K;
    localparam int N_W        = 10;
    localparam int K_W        = 8;
    localparam int NN_W       = 6;

    typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, STREAM, FINISHED} state_t;

    function automatic int b_addr(input int nn, input int k, input int half_k);
        return nn * half_k + k;
    endfunction
endpackage

// File: rtl/nn_result_skid.sv
// nn_result_skid: 2-entry valid/ready buffer absorbing the result RAM read latency
module nn_result_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    logic         pop;

    assign valid = count != 2'd0;
    assign data  = mem[rp];
    assign pop   = valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/nn_b_accumulator.sv
// nn_b_accumulator: accumulates A*W products into the b RAM, then streams every b word out
module nn_b_accumulator
    import nn_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int K            = 2 * HALF_K,
    parameter int NN_OUT       = B_WORDS / HALF_K,
    parameter int Q            = Q_DEF,
    parameter int BRAM_LATENCY = LAT_DEF
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            addr_valid_in,
    input  logic            done_in,
    input  logic [N_W-1:0]  n_idx_in,
    input  logic [K_W-1:0]  k_idx_in,
    input  logic [NN_W-1:0] nn_idx_in,
    input  logic [Q-1:0]    a_data_in,
    input  logic [Q-1:0]    w_data_in,
    input  logic            res_ready_in,
    output logic            res_valid_out,
    output logic [Q-1:0]    res_data_out,
    output logic [NN_W-1:0] res_nn_out,
    output logic [K_W-1:0]  res_k_out,
    output logic            res_last_out,
    output logic            busy_out,
    output logic            finished_out
);
    localparam int HK  = K / 2;
    localparam int BW  = NN_OUT * HK;
    localparam int AW  = $clog2(BW);
    localparam int FCW = $clog2(BRAM_LATENCY + 3);
    localparam int SW  = Q + NN_W + K_W + 1;

    if (BW < 4) begin : g_bw_check
        $error("NN_OUT*HALF_K must be at least 4");
    end
    if (DEPTH < 1 || DEPTH > 2 ** N_W) begin : g_depth_check
        $error("DEPTH does not fit the n index");
    end

    state_t            state;
    logic [FCW-1:0]    flush_cnt;
    logic              accept;
    logic [BRAM_LATENCY-1:0] p_valid;
    logic [N_W-1:0]    p_n  [BRAM_LATENCY];
    logic [K_W-1:0]    p_k  [BRAM_LATENCY];
    logic [NN_W-1:0]   p_nn [BRAM_LATENCY];
    logic              d_valid;
    logic              d_first;
    logic [Q-1:0]      prod;
    logic [AW-1:0]     d_addr;
    logic              s1_valid;
    logic              s1_first;
    logic [AW-1:0]     s1_addr;
    logic [Q-1:0]      s1_prod;
    logic              s2_valid;
    logic [AW-1:0]     s2_addr;
    logic [Q-1:0]      s2_sum;
    logic [Q-1:0]      sum;
    logic [Q-1:0]      ram [BW];
    logic [Q-1:0]      rd_q;
    logic [AW-1:0]     rd_addr;
    logic [AW:0]       s_cnt;
    logic [NN_W-1:0]   s_nn;
    logic [K_W-1:0]    s_k;
    logic              pend_valid;
    logic              pend_last;
    logic [NN_W-1:0]   pend_nn;
    logic [K_W-1:0]    pend_k;
    logic [1:0]        skid_count;
    logic [2:0]        occ;
    logic              pop;
    logic              issue;
    logic [SW-1:0]     skid_data;

    assign accept = addr_valid_in && (state == IDLE || state == ACCUM);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            p_valid <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                p_n[i]  <= '0;
                p_k[i]  <= '0;
                p_nn[i] <= '0;
            end
        end else begin
            for (int i = BRAM_LATENCY - 1; i > 0; i--) begin
                p_valid[i] <= p_valid[i-1];
                p_n[i]     <= p_n[i-1];
                p_k[i]     <= p_k[i-1];
                p_nn[i]    <= p_nn[i-1];
            end
            p_valid[0] <= accept;
            p_n[0]     <= n_idx_in;
            p_k[0]     <= k_idx_in;
            p_nn[0]    <= nn_idx_in;
        end
    end

    assign d_valid = p_valid[BRAM_LATENCY-1];
    assign d_first = p_n[BRAM_LATENCY-1] == '0;
    assign prod    = a_data_in * w_data_in;
    assign d_addr  = AW'(b_addr(int'(p_nn[BRAM_LATENCY-1]), int'(p_k[BRAM_LATENCY-1]), HK));
    // n==0 overwrites, so stale RAM contents from earlier runs never leak in
    assign sum     = s1_first ? s1_prod : rd_q + s1_prod;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_addr  <= '0;
            s1_prod  <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_sum   <= '0;
        end else begin
            s1_valid <= d_valid;
            s1_first <= d_first;
            s1_addr  <= d_addr;
            s1_prod  <= prod;
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_sum   <= sum;
        end
    end

    assign rd_addr = state == STREAM ? s_cnt[AW-1:0] : d_addr;

    always_ff @(posedge clk_in) begin
        if (s2_valid) ram[s2_addr] <= s2_sum;
        rd_q <= ram[rd_addr];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE:   state <= done_in ? FINISHED : addr_valid_in ? ACCUM : IDLE;
                ACCUM:  if (done_in) begin
                    state     <= FLUSH;
                    flush_cnt <= '0;
                end
                FLUSH:  if (flush_cnt == FCW'(BRAM_LATENCY + 2)) state <= STREAM;
                        else flush_cnt <= flush_cnt + 1'b1;
                STREAM: if (pop && res_last_out) state <= FINISHED;
                default: ;
            endcase
        end
    end

    // a read is only issued when its data is guaranteed a skid slot one cycle later
    assign pop   = res_valid_out && res_ready_in;
    assign occ   = 3'(skid_count) + 3'(pend_valid) - 3'(pop);
    assign issue = state == STREAM && s_cnt != (AW+1)'(BW) && occ < 3'd2;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s_cnt      <= '0;
            s_nn       <= '0;
            s_k        <= '0;
            pend_valid <= 1'b0;
            pend_last  <= 1'b0;
            pend_nn    <= '0;
            pend_k     <= '0;
        end else begin
            pend_valid <= issue;
            if (issue) begin
                pend_nn   <= s_nn;
                pend_k    <= s_k;
                pend_last <= s_cnt == (AW+1)'(BW - 1);
                s_cnt     <= s_cnt + 1'b1;
                s_k       <= s_k == K_W'(HK - 1) ? '0 : s_k + 1'b1;
                s_nn      <= s_k == K_W'(HK - 1) ? s_nn + 1'b1 : s_nn;
            end
        end
    end

    nn_result_skid #(.W(SW)) u_skid (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (pend_valid),
        .push_data ({rd_q, pend_nn, pend_k, pend_last}),
        .ready     (res_ready_in),
        .valid     (res_valid_out),
        .data      (skid_data),
        .count     (skid_count)
    );

    assign {res_data_out, res_nn_out, res_k_out, res_last_out} = skid_data;
    assign busy_out     = state == ACCUM || state == FLUSH || state == STREAM;
    assign finished_out = state == FINISHED;
endmodule

// File: tb/tb_nn_b_accumulator.sv
// tb_nn_b_accumulator: randomized and directed checks of b accumulation and result streaming
module tb_nn_b_accumulator;
    localparam int DEPTH = 2;
    localparam int K = 4;
    localparam int NN_OUT = 2;
    localparam int Q = 16;
    localparam int LAT = 2;
    localparam int HK = K / 2;
    localparam int BWD = NN_OUT * HK;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        addr_valid_in;
    logic        done_in;
    logic [9:0]  n_idx_in;
    logic [7:0]  k_idx_in;
    logic [5:0]  nn_idx_in;
    logic [15:0] a_data_in;
    logic [15:0] w_data_in;
    logic        res_ready_in;
    logic        res_valid_out;
    logic [15:0] res_data_out;
    logic [5:0]  res_nn_out;
    logic [7:0]  res_k_out;
    logic        res_last_out;
    logic        busy_out;
    logic        finished_out;

    int checks = 0;
    int failures = 0;
    int a_m [DEPTH][HK];
    int w_m [DEPTH][NN_OUT];
    logic [15:0] a_hist [LAT];
    logic [15:0] w_hist [LAT];
    logic [15:0] exp_b [BWD];

    nn_b_accumulator #(.DEPTH(DEPTH), .K(K), .NN_OUT(NN_OUT), .Q(Q), .BRAM_LATENCY(LAT)) dut (
        .clk_in(clk), .rst_in(rst_in), .addr_valid_in(addr_valid_in), .done_in(done_in),
        .n_idx_in(n_idx_in), .k_idx_in(k_idx_in), .nn_idx_in(nn_idx_in),
        .a_data_in(a_data_in), .w_data_in(w_data_in), .res_ready_in(res_ready_in),
        .res_valid_out(res_valid_out), .res_data_out(res_data_out), .res_nn_out(res_nn_out),
        .res_k_out(res_k_out), .res_last_out(res_last_out), .busy_out(busy_out),
        .finished_out(finished_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // behavioural BRAM: data for a beat appears LAT cycles after its address
    task automatic drive(input logic v, input int n, input int k, input int nn);
        addr_valid_in = v;
        n_idx_in = 10'(n);
        k_idx_in = 8'(k);
        nn_idx_in = 6'(nn);
        a_data_in = a_hist[LAT-1];
        w_data_in = w_hist[LAT-1];
        for (int i = LAT - 1; i > 0; i--) begin
            a_hist[i] = a_hist[i-1];
            w_hist[i] = w_hist[i-1];
        end
        a_hist[0] = v ? 16'(a_m[n][k]) : 16'hxxxx;
        w_hist[0] = v ? 16'(w_m[n][nn]) : 16'hxxxx;
        tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        done_in = 1'b0;
        addr_valid_in = 1'b0;
        res_ready_in = 1'b1;
        n_idx_in = '0;
        k_idx_in = '0;
        nn_idx_in = '0;
        a_data_in = '0;
        w_data_in = '0;
        for (int i = 0; i < LAT; i++) begin
            a_hist[i] = '0;
            w_hist[i] = '0;
        end
        tick();
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    task automatic fill(input int a, input int w);
        for (int n = 0; n < DEPTH; n++) begin
            for (int k = 0; k < HK; k++) a_m[n][k] = a;
            for (int nn = 0; nn < NN_OUT; nn++) w_m[n][nn] = w;
        end
    endtask

    task automatic calc_expected();
        for (int nn = 0; nn < NN_OUT; nn++)
            for (int k = 0; k < HK; k++) begin
                longint s = 0;
                for (int n = 0; n < DEPTH; n++) s += longint'(a_m[n][k]) * longint'(w_m[n][nn]);
                exp_b[nn * HK + k] = 16'(s);
            end
    endtask

    task automatic run_accum(input int gap_at, input int gap_len, input bit rand_gap);
        int beat = 0;
        for (int n = 0; n < DEPTH; n++)
            for (int nn = 0; nn < NN_OUT; nn++)
                for (int k = 0; k < HK; k++) begin
                    if (beat == gap_at) repeat (gap_len) drive(1'b0, 0, 0, 0);
                    if (rand_gap) repeat ($urandom_range(0, 2)) drive(1'b0, 0, 0, 0);
                    drive(1'b1, n, k, nn);
                    if (beat == 0) begin
                        checks++;
                        if (busy_out !== 1'b1) begin
                            failures++;
                            $display("FAIL busy_after_first_beat got=%b exp=1", busy_out);
                        end
                    end
                    beat++;
                end
        done_in = 1'b1;
        repeat (LAT + 1) drive(1'b0, 0, 0, 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall the first three valid cycles
    task automatic stream_check(input int mode, input string tag);
        int got = 0;
        int cyc = 0;
        int vcyc = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic rdy;
        logic [31:0] prev = '0;
        logic [31:0] cur;
        while (got < BWD && cyc < 300) begin
            rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(res_valid_out && vcyc < 3);
            if (res_valid_out) vcyc++;
            res_ready_in = rdy;
            cur = {res_valid_out, res_data_out, res_nn_out, res_k_out, res_last_out};
            if (pv && !pr) begin
                checks++;
                if (cur !== prev) begin
                    failures++;
                    $display("FAIL %s hold_stable got=%h exp=%h", tag, cur, prev);
                end
            end
            if (res_valid_out && rdy) begin
                checks++;
                if (res_data_out !== exp_b[got] || res_nn_out !== 6'(got / HK) || res_k_out !== 8'(got % HK)
                    || res_last_out !== (got == BWD - 1)) begin
                    failures++;
                    $display("FAIL %s beat%0d got data=%h nn=%0d k=%0d last=%b exp data=%h nn=%0d k=%0d last=%b",
                             tag, got, res_data_out, res_nn_out, res_k_out, res_last_out,
                             exp_b[got], got / HK, got % HK, got == BWD - 1);
                end
                got++;
            end
            pv = res_valid_out;
            pr = rdy;
            prev = cur;
            tick();
            cyc++;
        end
        res_ready_in = 1'b1;
        checks++;
        if (got != BWD) begin
            failures++;
            $display("FAIL %s stream_timeout got=%0d beats exp=%0d", tag, got, BWD);
        end
        checks++;
        if (finished_out !== 1'b1 || res_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL %s end_state got fin=%b valid=%b busy=%b exp fin=1 valid=0 busy=0",
                     tag, finished_out, res_valid_out, busy_out);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        done_in = 1'b0;
        addr_valid_in = 1'b0;
        res_ready_in = 1'b0;
        tick();
        tick();
        checks++;
        if ({res_valid_out, res_data_out, res_nn_out, res_k_out, res_last_out, busy_out, finished_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b data=%h nn=%0d k=%0d last=%b busy=%b fin=%b exp all 0",
                     res_valid_out, res_data_out, res_nn_out, res_k_out, res_last_out, busy_out, finished_out);
        end
    endtask

    task automatic test_basic();
        do_reset();
        fill(1, 3);
        calc_expected();
        run_accum(-1, 0, 1'b0);
        stream_check(0, "basic");
    endtask

    task automatic test_wrap();
        do_reset();
        fill(16'hFFFF, 16'h0002);
        calc_expected();
        run_accum(-1, 0, 1'b0);
        stream_check(0, "wrap");
    endtask

    task automatic test_distinct();
        do_reset();
        for (int n = 0; n < DEPTH; n++) begin
            for (int k = 0; k < HK; k++) a_m[n][k] = n * 2 + k + 1;
            for (int nn = 0; nn < NN_OUT; nn++) w_m[n][nn] = nn + 1;
        end
        calc_expected();
        run_accum(-1, 0, 1'b0);
        stream_check(0, "distinct");
    endtask

    task automatic test_backpressure();
        do_reset();
        fill(1, 3);
        calc_expected();
        run_accum(-1, 0, 1'b0);
        stream_check(2, "backpressure");
    endtask

    task automatic test_gaps();
        do_reset();
        fill(1, 3);
        calc_expected();
        run_accum(3, 10, 1'b0);
        stream_check(0, "gaps");
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill(9, 3);
        for (int b = 0; b < 5; b++) drive(1'b1, b / BWD, b % HK, (b / HK) % NN_OUT);
        rst_in = 1'b1;
        addr_valid_in = 1'b0;
        tick();
        checks++;
        if (busy_out !== 1'b0 || res_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_abort got busy=%b valid=%b exp busy=0 valid=0", busy_out, res_valid_out);
        end
        fill(1, 3);
        calc_expected();
        do_reset();
        run_accum(-1, 0, 1'b0);
        stream_check(0, "reset_mid_rerun");
    endtask

    task automatic test_empty();
        do_reset();
        done_in = 1'b1;
        tick();
        tick();
        checks++;
        if (finished_out !== 1'b1 || res_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL empty_run got fin=%b valid=%b busy=%b exp fin=1 valid=0 busy=0",
                     finished_out, res_valid_out, busy_out);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int n = 0; n < DEPTH; n++) begin
                for (int k = 0; k < HK; k++) a_m[n][k] = int'($urandom_range(0, 16'hFFFF));
                for (int nn = 0; nn < NN_OUT; nn++) w_m[n][nn] = int'($urandom_range(0, 16'hFFFF));
            end
            calc_expected();
            run_accum(-1, 0, 1'b1);
            stream_check(1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_distinct();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_empty();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
